// File: rtl/conv_window_buffer.sv
// Streaming line buffer and KxK sliding-window generator for raster-order 96-bit RGB pixels.
// Emits one fully populated window per accepted pixel once K rows and K columns are available.
module conv_window_buffer #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [95:0]                                    pix_in,
  input  logic                                           pix_valid,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][95:0]  window_out,
  output logic                                           window_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0]                  win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]                   win_col,
  output logic                                           frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] KM1_ROW  = RW'(K - 1);
  localparam logic [CW-1:0] KM1_COL  = CW'(K - 1);

  logic [CW-1:0] col_q, col_d, rd_addr;
  logic [RW-1:0] row_q, row_d;
  logic          emit;

  logic [K-1:0][K-1:0][95:0] win_q;
  logic                      valid_q, done_q;
  logic [RW-1:0]             win_row_q;
  logic [CW-1:0]             win_col_q;

  logic [95:0] lb_rd [K-1];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Line buffers read one address ahead so the registered read already holds
  // the old contents of address col when the pixel at col is accepted.
  assign rd_addr = reset ? '0 : col_d;
  assign emit    = (row_q >= KM1_ROW) && (col_q >= KM1_COL);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_lb
      logic [95:0] mem [IMG_WIDTH];
      logic [95:0] rd_q;
      logic [95:0] wr_data;

      if (gi == 0) begin : g_first
        assign wr_data = pix_in;
      end else begin : g_chain
        assign wr_data = g_lb[gi-1].rd_q;
      end

      always_ff @(posedge clk) begin
        if (pix_valid && !reset) begin
          mem[col_q] <= wr_data;
        end
        rd_q <= mem[rd_addr];
      end

      assign lb_rd[gi] = rd_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      valid_q <= pix_valid && emit;
      done_q  <= pix_valid && emit && (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (pix_valid) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
        end
        // Bottom row is the live pixel; each row above comes from one more line of delay.
        win_q[K-1][K-1] <= pix_in;
        for (int r = 0; r < K - 1; r++) begin
          win_q[r][K-1] <= lb_rd[K-2-r];
        end
        if (emit) begin
          win_row_q <= row_q - KM1_ROW;
          win_col_q <= col_q - KM1_COL;
        end
      end
    end
  end

  assign window_out   = win_q;
  assign window_valid = valid_q;
  assign frame_done   = done_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;

endmodule
